// File: rtl/myseg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | myseg_pkg : shared types and hex->segment table for the myseg scan  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package myseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } scan_state_e;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  // Active-high {g,f,e,d,c,b,a}, indexed by hex value 0..F
  localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage
`default_nettype wire

// File: rtl/myseg_hex_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | myseg_hex_decoder : combinational 4-bit hex to 7-segment decode     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module myseg_hex_decoder
  import myseg_pkg::*;
(
  input  logic [DIGIT_W-1:0] hex,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_LUT[hex];
  end

endmodule
`default_nettype wire

// File: rtl/myseg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | myseg_scan_driver : time-multiplexed 7-segment scan driver with     |
// | frame-start shadowing and inter-digit dead time.                    |
// | Optional macro MYSEG_BRIGHTNESS_EN adds cfg_bright PWM dimming.     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module myseg_scan_driver
  import myseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          cfg_en,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] cfg_digits,
  input  logic [NUM_DIGITS-1:0]         cfg_dp,
  input  logic [NUM_DIGITS-1:0]         cfg_blank,
`ifdef MYSEG_BRIGHTNESS_EN
  input  logic [3:0]                    cfg_bright,
`endif
  output logic [SEG_W-1:0]              seg_n,
  output logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          frame_done
);

  localparam int SLOT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SLOT_W-1:0]     BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
  localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_INV    = {SEG_W{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_INV     = {NUM_DIGITS{ACTIVE_LOW}};

  scan_state_e state;
  scan_state_e state_nxt;

  logic [SLOT_W-1:0]             slot_cnt;
  logic [SLOT_W-1:0]             slot_nxt;
  logic [IDX_W-1:0]              digit_idx;
  logic [IDX_W-1:0]              idx_nxt;
  logic                          frame_nxt;
  logic                          load_shadow;

  logic [DIGIT_W*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]         sh_dp;
  logic [NUM_DIGITS-1:0]         sh_blank;
  logic [DIGIT_W*NUM_DIGITS-1:0] digits_nxt;
  logic [NUM_DIGITS-1:0]         dp_nxt;
  logic [NUM_DIGITS-1:0]         blank_nxt;

  logic [SEG_W-1:0]              dec_seg;
  logic [SEG_W-1:0]              seg_act;
  logic                          dp_act;
  logic [NUM_DIGITS-1:0]         an_act;
  logic                          lit;
  logic                          pwm_gate;

`ifdef MYSEG_BRIGHTNESS_EN
  logic [3:0] pwm_cnt;
  logic [3:0] pwm_nxt;
  logic [3:0] sh_bright;
  logic [3:0] bright_nxt;

  assign bright_nxt = load_shadow ? cfg_bright : sh_bright;
  // PWM phase restarts on every ON entry so each digit gets identical duty
  assign pwm_nxt    = (state_nxt == ON && state == ON) ? pwm_cnt + 4'd1 : 4'd0;
  assign pwm_gate   = (pwm_nxt <= bright_nxt);
`else
  assign pwm_gate   = 1'b1;
`endif

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter sequencing
  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot_cnt;
    idx_nxt     = digit_idx;
    frame_nxt   = 1'b0;
    load_shadow = 1'b0;
    if (!cfg_en) begin
      state_nxt = IDLE;
      slot_nxt  = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = BLANK;
          slot_nxt    = '0;
          idx_nxt     = '0;
          load_shadow = 1'b1;
        end
        BLANK: begin
          slot_nxt = slot_cnt + 1'b1;
          if (slot_cnt == BLANK_LAST) begin
            state_nxt = ON;
          end
        end
        ON: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = '0;
            state_nxt = BLANK;
            if (digit_idx == IDX_LAST) begin
              idx_nxt     = '0;
              frame_nxt   = 1'b1;
              load_shadow = 1'b1;
            end else begin
              idx_nxt = digit_idx + 1'b1;
            end
          end else begin
            slot_nxt = slot_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          slot_nxt  = '0;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  assign digits_nxt = load_shadow ? cfg_digits : sh_digits;
  assign dp_nxt     = load_shadow ? cfg_dp     : sh_dp;
  assign blank_nxt  = load_shadow ? cfg_blank  : sh_blank;

  myseg_hex_decoder u_dec (
    .hex (digits_nxt[{idx_nxt, 2'b00} +: DIGIT_W]),
    .seg (dec_seg)
  );

  assign lit = (state_nxt != IDLE) && !blank_nxt[idx_nxt];

  // Output decode from next-cycle values so the registered outputs line up with state
  always_comb begin
    seg_act = '0;
    dp_act  = 1'b0;
    an_act  = '0;
    if (lit) begin
      seg_act = dec_seg;
      dp_act  = dp_nxt[idx_nxt];
      if (state_nxt == ON && pwm_gate) begin
        an_act[idx_nxt] = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      sh_digits  <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      frame_done <= 1'b0;
      seg_n      <= SEG_INV;
      dp_n       <= ACTIVE_LOW;
      an_n       <= AN_INV;
`ifdef MYSEG_BRIGHTNESS_EN
      pwm_cnt    <= 4'd0;
      sh_bright  <= 4'd0;
`endif
    end else begin
      slot_cnt   <= slot_nxt;
      digit_idx  <= idx_nxt;
      sh_digits  <= digits_nxt;
      sh_dp      <= dp_nxt;
      sh_blank   <= blank_nxt;
      frame_done <= frame_nxt;
      seg_n      <= seg_act ^ SEG_INV;
      dp_n       <= dp_act ^ ACTIVE_LOW;
      an_n       <= an_act ^ AN_INV;
`ifdef MYSEG_BRIGHTNESS_EN
      pwm_cnt    <= pwm_nxt;
      sh_bright  <= bright_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_myseg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_myseg_scan_driver : scoreboard bench for myseg_scan_driver       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_myseg_scan_driver;

  localparam int ND = 4;
  localparam int CD = 20;
  localparam int BC = 4;
  localparam logic [12:0] IDLE_W = {1'b0, 4'hF, 7'h7F, 1'b1};

  logic        clk = 1'b0;
  logic        arst;
  logic        en;
  logic [15:0] dig;
  logic [3:0]  dp;
  logic [3:0]  bl;
`ifdef MYSEG_BRIGHTNESS_EN
  logic [3:0]  bright;
`endif
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  always #5 clk = ~clk;

  myseg_scan_driver #(
    .NUM_DIGITS   (ND),
    .CLK_DIV      (CD),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .ACLK       (clk),
    .ARESET     (arst),
    .cfg_en     (en),
    .cfg_digits (dig),
    .cfg_dp     (dp),
    .cfg_blank  (bl),
`ifdef MYSEG_BRIGHTNESS_EN
    .cfg_bright (bright),
`endif
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  typedef struct {
    string       tag;
    logic [12:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got fd=%b an=%h seg=%h dp=%b, expected fd=%b an=%h seg=%h dp=%b",
               tag, $time, obs[12], obs[11:8], obs[7:1], obs[0],
               exp[12], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq(e.tag, {frame_done, an_n, seg_n, dp_n}, e.val);
    end
  end

  // Reference model: position within frame plus bench-side shadow copy
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_bl;
  logic [3:0]  m_br;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [12:0] slot_word(input int pos, input bit fd);
    int         k;
    int         p;
    bit         on;
    logic [3:0] an;
    logic [3:0] h;
    k = pos / CD;
    p = pos % CD;
    if (m_bl[k]) return {fd, 4'hF, 7'h7F, 1'b1};
    on = (p >= BC);
`ifdef MYSEG_BRIGHTNESS_EN
    on = on && (((p - BC) % 16) <= int'(m_br));
`endif
    an = 4'hF;
    if (on) an[k] = 1'b0;
    h = m_dig[k*4 +: 4];
    return {fd, an, ~hex7(h), ~m_dp[k]};
  endfunction

  task automatic load_shadow();
    m_dig = dig;
    m_dp  = dp;
    m_bl  = bl;
`ifdef MYSEG_BRIGHTNESS_EN
    m_br  = bright;
`else
    m_br  = 4'hF;
`endif
  endtask

  // Inputs are already set; push expected outputs after the coming edge, then advance
  task automatic cycle(input string tag);
    exp_t e;
    bit   fd;
    fd = 1'b0;
    if (arst || !en) begin
      m_run = 1'b0;
      e.val = IDLE_W;
    end else begin
      if (!m_run) begin
        m_run = 1'b1;
        m_pos = 0;
        load_shadow();
      end else begin
        m_pos++;
        if (m_pos == ND*CD) begin
          m_pos = 0;
          load_shadow();
          fd = 1'b1;
        end
      end
      e.val = slot_word(m_pos, fd);
    end
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    arst = 1'b1;
    en   = 1'b0;
    dig  = 16'h1234;
    dp   = 4'h0;
    bl   = 4'h0;
`ifdef MYSEG_BRIGHTNESS_EN
    bright = 4'hF;
`endif
    repeat (3) cycle("reset");
    arst = 1'b0;
    repeat (2) cycle("idle");

    en = 1'b1;
    repeat (170) cycle("scan_1234");

    dig = 16'hABCD;
    repeat (160) cycle("tear_free");

    bl = 4'b0010;
    dp = 4'b0001;
    repeat (100) cycle("blank_dp");

    guard = 0;
    while (m_pos != 2*CD + 10 && guard < 200) begin
      cycle("to_digit2_on");
      guard++;
    end
    en = 1'b0;
    repeat (4) cycle("disable_mid_on");
    en = 1'b1;
    repeat (30) cycle("reenable");

    guard = 0;
    while (m_pos != ND*CD - 1 && guard < 200) begin
      cycle("to_frame_end");
      guard++;
    end
    en = 1'b0;
    repeat (2) cycle("disable_at_frame_end");
    en  = 1'b1;
    dig = 16'h80F5;
    repeat (25) cycle("reenable2");

    arst = 1'b1;
    repeat (2) cycle("reset_midslot");
    arst = 1'b0;
    repeat (90) cycle("after_reset");

`ifdef MYSEG_BRIGHTNESS_EN
    bl = 4'h0;
    bright = 4'd3;
    repeat (170) cycle("bright3");
    bright = 4'd15;
    repeat (170) cycle("bright15");
`endif

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      check_eq("scoreboard_drain", 13'(sb.size()), 13'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
